// File: rtl/switch_input_pkg.sv
// Shared constants and types for the slide-switch capture block.
// Debouncing is compiled in only when SWITCH_DEBOUNCE_EN is defined.
package switch_input_pkg;

  localparam int SYNC_STAGES      = 2;
  localparam int SW_WIDTH         = 16;
  localparam int DEBOUNCE_DEFAULT = 100000;

  // What the event register does on a given edge, decided before any state moves.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_FIRST,
    EV_MERGE,
    EV_REPLACE,
    EV_CLEAR
  } event_action_e;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/switch_input_capture_if.sv
// CPU-facing bundle of the switch capture block: raw pins in, debounced state and change event out.
// The slave modport is the capture block, the master modport is the CPU side.
interface switch_input_capture_if
  import switch_input_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] Switches;
  logic [WIDTH-1:0] SwitchState;
  logic [WIDTH-1:0] ChangeMask;
  logic             EventValid;
  logic             EventAck;
  logic             Overrun;

  modport master (
    output Switches,
    output EventAck,
    input  SwitchState,
    input  ChangeMask,
    input  EventValid,
    input  Overrun
  );

  modport slave (
    input  Switches,
    input  EventAck,
    output SwitchState,
    output ChangeMask,
    output EventValid,
    output Overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Multi-bit flop-chain synchroniser for asynchronous pins; each bit is synchronised independently.
// Asynchronous active-low reset clears every stage.
module sync_2ff
  import switch_input_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_input_capture.sv
// Conditions the board slide switches for the CPU: synchronise, debounce, then report changes via valid/ack.
// Define SWITCH_DEBOUNCE_EN to include the shared debounce counter; otherwise changes pass straight through.
module switch_input_capture
  import switch_input_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 Clkpin,
  input  logic                 reset,
  switch_input_capture_if.slave bus
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] diff;
  logic             update;
  event_action_e    action;

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("switch_input_capture: DEBOUNCE_CYCLES must be at least 2");
  end

  sync_2ff #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk  (Clkpin),
    .rst_n(reset),
    .d    (bus.Switches),
    .q    (sync_q)
  );

`ifdef SWITCH_DEBOUNCE_EN
  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_prev_q, sync_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One counter for all bits: any movement, or agreement with the accepted value, restarts the window.
  always_comb begin
    sync_prev_d = sync_q;
    cnt_d       = cnt_q;
    update      = 1'b0;
    if ((sync_q != sync_prev_q) || (sync_q == stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      update = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clkpin or negedge reset) begin
    if (!reset) begin
      sync_prev_q <= '0;
      cnt_q       <= '0;
    end else begin
      sync_prev_q <= sync_prev_d;
      cnt_q       <= cnt_d;
    end
  end
`else
  assign update = (sync_q != stable_q);
`endif

  // An update always beats a simultaneous ack, so a fresh change is never lost.
  always_comb begin
    diff   = stable_q ^ sync_q;
    action = EV_NONE;
    if (update) begin
      if (!valid_q) begin
        action = EV_FIRST;
      end else if (bus.EventAck) begin
        action = EV_REPLACE;
      end else begin
        action = EV_MERGE;
      end
    end else if (bus.EventAck && valid_q) begin
      action = EV_CLEAR;
    end
  end

  always_comb begin
    stable_d  = stable_q;
    mask_d    = mask_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    case (action)
      EV_FIRST: begin
        stable_d = sync_q;
        mask_d   = diff;
        valid_d  = 1'b1;
      end
      EV_MERGE: begin
        stable_d  = sync_q;
        mask_d    = mask_q | diff;
        overrun_d = 1'b1;
      end
      EV_REPLACE: begin
        stable_d  = sync_q;
        mask_d    = diff;
        overrun_d = 1'b0;
      end
      EV_CLEAR: begin
        valid_d   = 1'b0;
        mask_d    = '0;
        overrun_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clkpin or negedge reset) begin
    if (!reset) begin
      stable_q  <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.SwitchState = stable_q;
  assign bus.ChangeMask  = mask_q;
  assign bus.EventValid  = valid_q;
  assign bus.Overrun     = overrun_q;

endmodule

// File: tb/tb_switch_input_capture.sv
// Directed bench for switch_input_capture with a 4-cycle debounce window.
// Expected latency follows SWITCH_DEBOUNCE_EN so the same bench covers both builds.
module tb_switch_input_capture;

  localparam int DEB = 4;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int LAT = 2 + 1 + DEB;
`else
  localparam int LAT = 3;
`endif

  // ack_mode: 0 = no ack, 1 = ack on the first edge, 2 = ack on the edge the update lands
  typedef struct {
    logic [15:0] sw;
    int          ack_mode;
    int          hold;
    logic [15:0] exp_state;
    logic [15:0] exp_mask;
    logic        exp_valid;
    logic        exp_ovr;
  } vec_t;

  logic Clkpin = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [8];

  switch_input_capture_if #(.WIDTH(16)) bus ();

  switch_input_capture #(
    .WIDTH          (16),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clkpin(Clkpin),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clkpin = ~Clkpin;

  function automatic vec_t mk(input logic [15:0] sw, input int ack_mode, input int hold,
                              input logic [15:0] st, input logic [15:0] mk_mask,
                              input logic v, input logic o);
    vec_t r;
    r.sw        = sw;
    r.ack_mode  = ack_mode;
    r.hold      = hold;
    r.exp_state = st;
    r.exp_mask  = mk_mask;
    r.exp_valid = v;
    r.exp_ovr   = o;
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] st, input logic [15:0] m,
                               input logic v, input logic o);
    check_val($sformatf("%s.state", tag), 32'(bus.SwitchState), 32'(st));
    check_val($sformatf("%s.mask", tag), 32'(bus.ChangeMask), 32'(m));
    check_val($sformatf("%s.valid", tag), 32'(bus.EventValid), 32'(v));
    check_val($sformatf("%s.overrun", tag), 32'(bus.Overrun), 32'(o));
  endtask

  task automatic ack_pulse();
    bus.EventAck = 1'b1;
    @(negedge Clkpin);
    bus.EventAck = 1'b0;
  endtask

  initial begin
    logic seen;

    // Table starts from a pending 0x00A5 event and ends with 0x0F0F pending.
    vecs[0] = mk(16'h80A5, 0, LAT + 2, 16'h80A5, 16'h80A5, 1'b1, 1'b1);
    vecs[1] = mk(16'h80A5, 1, 2,       16'h80A5, 16'h0000, 1'b0, 1'b0);
    vecs[2] = mk(16'h80A5, 1, 2,       16'h80A5, 16'h0000, 1'b0, 1'b0);
    vecs[3] = mk(16'h80A4, 0, LAT + 2, 16'h80A4, 16'h0001, 1'b1, 1'b0);
    vecs[4] = mk(16'h80A5, 0, LAT + 2, 16'h80A5, 16'h0001, 1'b1, 1'b1);
    vecs[5] = mk(16'h8000, 2, LAT + 2, 16'h8000, 16'h00A5, 1'b1, 1'b0);
    vecs[6] = mk(16'h8000, 1, 2,       16'h8000, 16'h0000, 1'b0, 1'b0);
    vecs[7] = mk(16'h0F0F, 0, LAT + 2, 16'h0F0F, 16'h8F0F, 1'b1, 1'b0);

    reset        = 1'b1;
    bus.Switches = 16'h0000;
    bus.EventAck = 1'b0;
    #1 reset = 1'b0;
    #1 check_outputs("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge Clkpin);
    reset = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clkpin);
      if (bus.EventValid) seen = 1'b1;
    end
    check_val("idle_valid_seen", 32'(seen), 32'd0);
    check_outputs("idle", 16'h0000, 16'h0000, 1'b0, 1'b0);

    bus.Switches = 16'h00A5;
    repeat (LAT - 1) @(negedge Clkpin);
    check_val("latency_early_valid", 32'(bus.EventValid), 32'd0);
    @(negedge Clkpin);
    check_outputs("latency_exact", 16'h00A5, 16'h00A5, 1'b1, 1'b0);

    for (int v = 0; v < 8; v++) begin
      bus.Switches = vecs[v].sw;
      for (int c = 1; c <= vecs[v].hold; c++) begin
        bus.EventAck = (vecs[v].ack_mode == 1 && c == 1) || (vecs[v].ack_mode == 2 && c == LAT);
        @(negedge Clkpin);
      end
      bus.EventAck = 1'b0;
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_state, vecs[v].exp_mask,
                    vecs[v].exp_valid, vecs[v].exp_ovr);
    end

    // Reset between clock edges with a count in flight and an event pending.
    bus.Switches = 16'h00FF;
    repeat (5) @(negedge Clkpin);
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge Clkpin);
    reset = 1'b1;
    repeat (LAT - 1) @(negedge Clkpin);
    check_val("rerun_early_valid", 32'(bus.EventValid), 32'd0);
    @(negedge Clkpin);
    check_outputs("rerun", 16'h00FF, 16'h00FF, 1'b1, 1'b0);
    ack_pulse();

`ifdef SWITCH_DEBOUNCE_EN
    bus.Switches = 16'h00FE;
    repeat (LAT + 2) @(negedge Clkpin);
    ack_pulse();
    check_outputs("bounce_base", 16'h00FE, 16'h0000, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.Switches = (i % 2 == 0) ? 16'h00FF : 16'h00FE;
      repeat (2) begin
        @(negedge Clkpin);
        if (bus.EventValid) seen = 1'b1;
      end
    end
    check_val("bounce_no_event", 32'(seen), 32'd0);
    bus.Switches = 16'h00FF;
    repeat (LAT + 2) @(negedge Clkpin);
    check_outputs("bounce_settle", 16'h00FF, 16'h0001, 1'b1, 1'b0);
`else
    bus.Switches = 16'h00FE;
    @(negedge Clkpin);
    bus.Switches = 16'h00FF;
    repeat (5) @(negedge Clkpin);
    check_outputs("glitch", 16'h00FF, 16'h0001, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
